number_divisibility_scanner: RTL and testbench
==============================================

Name: number_divisibility_scanner

Overview:
Parametrised, sequential successor to the team's combinational number-to-LED divisibility decoder. It accepts a WIDTH-bit unsigned number through a start/ready handshake and tests it against NUM_DIV configurable divisors. The test uses a bit-serial residue engine that processes the number MSB-first, one bit per clock. Each divisor drives one LED output bit, and the LED register holds the last result until the next result is ready.

Parameters:
WIDTH, 8, bit width of input number
NUM_DIV, 5, number of divisors / LED channels
DIV_W, 5, bit width of each divisor field
DIVISORS, {5'd2,5'd3,5'd4,5'd5,5'd30}, packed NUM_DIV*DIV_W vector; field i (bits i*DIV_W +: DIV_W) is the divisor for LED[i]

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to test num; accepted only when ready=1
num  input  WIDTH  unsigned number, sampled on the accepting edge
ready  output  1  high when idle and able to accept start
busy  output  1  high while scanning (always equal to ~ready)
done  output  1  one-cycle pulse when LED is updated with a new result
LED  output  NUM_DIV  LED[i]=1 iff the last accepted num is divisible by divisor field i

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on port reset.
- Reset values: LED=0, done=0, state=IDLE (ready=1, busy=0), shift register=0, residues=0, bit counter=0.
- FSM states:
  - IDLE: ready=1. On start=1, latch num into the shift register, clear all residues to 0, load bit counter=WIDTH-1, and go to SCAN.
  - SCAN: ready=0. On each edge, take bit b = current MSB of the shift register, then shift left.
    - For every channel, t = 2*r_i + b is computed in DIV_W+1 bits.
    - r_i_next = t - d_i if t >= d_i, else t.
    - Decrement the bit counter.
  - Leaving SCAN: on the edge where the counter is 0, go to IDLE and register LED[i] = (r_i_next == 0). In the same edge, set done=1 for exactly one cycle.
- Latency: start accepted on edge k; LED and done are valid after edge k+WIDTH. Throughput is one number per WIDTH+1 cycles.
- Back-to-back: ready is already 1 in the cycle where done=1. If start=1 in that cycle, it is accepted; LED keeps its new value during the next scan.
- A start seen while busy is ignored: num is not re-sampled and there is no effect on the scan in progress.
- LED changes only on a done edge or on reset. It is never changed by a start alone.
- Divisor field edge cases:
  - Field value 1: that channel's LED bit is always 1 on done.
  - Field value 0: that channel's LED bit is always 0 (illegal divisor, forced low; no arithmetic is performed).
- num=0: every channel with divisor >= 1 reports 1.
- Residues always satisfy r_i < d_i, so 2*r_i + 1 < 2*d_i and a single conditional subtract is sufficient. No wrap-around is possible in DIV_W+1 bits.
- Reset asserted mid-scan: on the next edge the block returns to IDLE with LED=0, and no done pulse is produced for the aborted number.
- Reset and start asserted together: reset wins, and start is not accepted.
- done is never asserted for two consecutive cycles.
- The block is fully synchronous: no latches, and no combinational path from start to LED.

Test Plan:
- Defaults, reset then start with num=30 → ready drops after the accepting edge; 8 edges later done=1 for 1 cycle and LED=5'b11011 (2,3,5,30 divide 30; 4 does not).
- Sweep num=0, 7, 12, 25, 240, 255 → LED=11111, 00000, 11100, 00010, 11111, 01010 respectively; each done pulse lands exactly WIDTH edges after acceptance.
- start held high with num=12 then num=25 → done pulses 9 cycles apart with LED=11100 then 00010; LED holds 11100 through the second scan.
- Accept num=30, then pulse start with num=7 on scan cycle 3 → second start is ignored; result is LED=11011, and ready stays low until the done cycle.
- Accept num=240, assert reset on scan cycle 4 → LED=0, done never pulses, and ready=1 on the edge after reset; a fresh num=25 then returns LED=00010.
- Override WIDTH=12, DIV_W=4, DIVISORS={4'd7,4'd9,4'd11,4'd13,4'd3}, num=3003 → LED=5'b10111 after 12 edges. Also check a field set to 4'd1 (bit always 1) and a field set to 4'd0 (bit always 0).

Source files
------------

// File: rtl/number_divisibility_scanner_if.sv
// Handshake bundle for the divisibility scanner: request side (start/num)
// and result side (ready/busy/done/LED).
interface number_divisibility_scanner_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_DIV = 5
);
    logic               start;
    logic [WIDTH-1:0]   num;
    logic               ready;
    logic               busy;
    logic               done;
    logic [NUM_DIV-1:0] LED;

    modport master (
        output start, num,
        input  ready, busy, done, LED
    );

    modport slave (
        input  start, num,
        output ready, busy, done, LED
    );
endinterface

// File: rtl/number_divisibility_scanner.sv
// Bit-serial divisibility tester: shifts num in MSB-first and keeps one running
// residue per divisor; LED[i] reports divisibility by field i when the scan ends.
module number_divisibility_scanner #(
    parameter int                         WIDTH    = 8,
    parameter int                         NUM_DIV  = 5,
    parameter int                         DIV_W    = 5,
    parameter logic [NUM_DIV*DIV_W-1:0]   DIVISORS = {5'd2, 5'd3, 5'd4, 5'd5, 5'd30}
) (
    input  logic                          clk,
    input  logic                          reset,
    number_divisibility_scanner_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [DIV_W-1:0]   res_q [NUM_DIV];
    logic [DIV_W-1:0]   res_d [NUM_DIV];
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_DIV-1:0] led_q, led_d;
    logic               done_q;
    logic               ready_c;
    logic               accept;
    logic               last_bit;
    logic               scan_bit;

    // One MSB-first step: r' = (2r + b) mod d. Since r < d, one subtract suffices.
    function automatic logic [DIV_W-1:0] residue_step(
        input logic [DIV_W-1:0] r,
        input logic             b,
        input logic [DIV_W-1:0] d
    );
        logic [DIV_W:0] t;
        t = {r, b};
        if (d == '0)
            return '0;
        if (t >= {1'b0, d})
            return DIV_W'(t - {1'b0, d});
        return t[DIV_W-1:0];
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        accept   = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                last_bit = (cnt_q == '0);
                if (last_bit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign scan_bit = shreg_q[WIDTH-1];

    always_comb begin
        for (int i = 0; i < NUM_DIV; i++) begin
            res_d[i] = residue_step(res_q[i], scan_bit, DIVISORS[i*DIV_W +: DIV_W]);
            // A zero divisor is illegal and always reports "not divisible".
            led_d[i] = (DIVISORS[i*DIV_W +: DIV_W] != '0) && (res_d[i] == '0);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
            // NOTE: the residue array is a handful of flops, not a RAM, so resetting it is cheap and keeps state defined.
            for (int i = 0; i < NUM_DIV; i++)
                res_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shreg_q <= bus.num;
                cnt_q   <= CNT_W'(WIDTH - 1);
                for (int i = 0; i < NUM_DIV; i++)
                    res_q[i] <= '0;
            end else if (state_q == SCAN) begin
                shreg_q <= shreg_q << 1;
                cnt_q   <= cnt_q - CNT_W'(1);
                for (int i = 0; i < NUM_DIV; i++)
                    res_q[i] <= res_d[i];
                if (last_bit) begin
                    led_q  <= led_d;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ready = ready_c;
    assign bus.busy  = ~ready_c;
    assign bus.done  = done_q;
    assign bus.LED   = led_q;

    // Invariants the single-subtract residue update depends on.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!done_q || state_q == IDLE);
            for (int i = 0; i < NUM_DIV; i++) begin
                if (DIVISORS[i*DIV_W +: DIV_W] != '0)
                    assert (res_q[i] < DIVISORS[i*DIV_W +: DIV_W]);
            end
        end
    end

endmodule

// File: tb/tb_number_divisibility_scanner.sv
// Scoreboard bench for number_divisibility_scanner: default build plus two
// overridden builds (12-bit with 4-bit divisors, and one with divisor fields 1 and 0).
module tb_number_divisibility_scanner;

    localparam logic [19:0] BIG_DIVS  = {4'd7, 4'd9, 4'd11, 4'd13, 4'd3};
    localparam logic [19:0] EDGE_DIVS = {4'd1, 4'd0, 4'd3, 4'd5, 4'd15};

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [4:0] exp_q[$];
    logic [4:0] big_q[$];
    logic [4:0] edge_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    number_divisibility_scanner_if #(.WIDTH(8),  .NUM_DIV(5)) m_if ();
    number_divisibility_scanner_if #(.WIDTH(12), .NUM_DIV(5)) big_if ();
    number_divisibility_scanner_if #(.WIDTH(8),  .NUM_DIV(5)) edge_if ();

    number_divisibility_scanner u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    number_divisibility_scanner #(
        .WIDTH(12), .NUM_DIV(5), .DIV_W(4), .DIVISORS(BIG_DIVS)
    ) u_big (
        .clk   (clk),
        .reset (reset),
        .bus   (big_if)
    );

    number_divisibility_scanner #(
        .WIDTH(8), .NUM_DIV(5), .DIV_W(4), .DIVISORS(EDGE_DIVS)
    ) u_edge (
        .clk   (clk),
        .reset (reset),
        .bus   (edge_if)
    );

    // Reference: plain modulo on each 4-bit divisor field; zero field never divides.
    function automatic logic [4:0] model_led(input int n, input logic [19:0] divs);
        logic [4:0] led;
        logic [3:0] f;
        for (int i = 0; i < 5; i++) begin
            f = divs[i*4 +: 4];
            led[i] = (f != 4'd0) && ((n % int'(f)) == 0);
        end
        return led;
    endfunction

    function automatic logic done_of(input int which);
        if (which == 0) return m_if.done;
        if (which == 1) return big_if.done;
        return edge_if.done;
    endfunction

    // Bounded wait (sampled on falling edges) for a done pulse; no comparison here.
    task automatic wait_done(input int which, input int budget, output bit got, output int at);
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_of(which)) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
        end
    endtask

    task automatic start_main(input logic [7:0] n, input logic [4:0] e, output int acc);
        @(negedge clk);
        m_if.num   = n;
        m_if.start = 1'b1;
        exp_q.push_back(e);
        acc = cyc + 1;
        @(negedge clk);
        m_if.start = 1'b0;
    endtask

    function automatic logic [4:0] pop_main();
        if (exp_q.size() == 0) return 5'bxxxxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        reset         = 1'b1;
        m_if.start    = 1'b1;
        m_if.num      = 8'd30;
        big_if.start  = 1'b0;
        big_if.num    = '0;
        edge_if.start = 1'b0;
        edge_if.num   = '0;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        m_if.start = 1'b0;
        total++; if (m_if.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", m_if.ready); end
        total++; if (m_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", m_if.busy); end
        total++; if (m_if.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", m_if.done); end
        total++; if (m_if.LED !== 5'b00000) begin bad++; $display("FAIL reset_led: got %b want 00000", m_if.LED); end
        total++; if (big_if.LED !== 5'b00000 || big_if.ready !== 1'b1) begin
            bad++; $display("FAIL reset_big: led %b ready %b want 00000 1", big_if.LED, big_if.ready);
        end
        total++; if (edge_if.LED !== 5'b00000 || edge_if.ready !== 1'b1) begin
            bad++; $display("FAIL reset_edge: led %b ready %b want 00000 1", edge_if.LED, edge_if.ready);
        end
    endtask

    task automatic test_single();
        int acc, at;
        bit got;
        start_main(8'd30, 5'b11011, acc);
        total++; if (m_if.ready !== 1'b0 || m_if.busy !== 1'b1) begin
            bad++; $display("FAIL single_busy: ready %b busy %b want 0 1", m_if.ready, m_if.busy);
        end
        total++; if (m_if.LED !== 5'b00000) begin bad++; $display("FAIL single_led_early: got %b want 00000", m_if.LED); end
        wait_done(0, 20, got, at);
        total++; if (!got) begin bad++; $display("FAIL single_timeout: no done within 20 cycles"); end
        total++; if (at !== acc + 8) begin bad++; $display("FAIL single_latency: done at %0d want %0d", at, acc + 8); end
        total++; if (m_if.LED !== pop_main()) begin bad++; $display("FAIL single_led: got %b want 11011", m_if.LED); end
        total++; if (m_if.ready !== 1'b1) begin bad++; $display("FAIL single_ready_at_done: got %b want 1", m_if.ready); end
        @(negedge clk);
        total++; if (m_if.done !== 1'b0 || m_if.LED !== 5'b11011) begin
            bad++; $display("FAIL single_pulse: done %b led %b want 0 11011", m_if.done, m_if.LED);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] nums [6] = '{8'd0, 8'd7, 8'd12, 8'd25, 8'd240, 8'd255};
        logic [4:0] exps [6] = '{5'b11111, 5'b00000, 5'b11100, 5'b00010, 5'b11111, 5'b01010};
        int acc, at;
        bit got;
        logic [4:0] e;
        for (int k = 0; k < 6; k++) begin
            start_main(nums[k], exps[k], acc);
            wait_done(0, 20, got, at);
            e = pop_main();
            total++; if (!got || at !== acc + 8) begin
                bad++; $display("FAIL sweep_latency num=%0d: got=%0b at %0d want %0d", nums[k], got, at, acc + 8);
            end
            total++; if (m_if.LED !== e) begin
                bad++; $display("FAIL sweep_led num=%0d: got %b want %b", nums[k], m_if.LED, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc1, at1, at2;
        bit got1, got2, hold_ok;
        @(negedge clk);
        m_if.num   = 8'd12;
        m_if.start = 1'b1;
        exp_q.push_back(5'b11100);
        acc1 = cyc + 1;
        @(negedge clk);
        m_if.num = 8'd25;
        wait_done(0, 20, got1, at1);
        exp_q.push_back(5'b00010);
        total++; if (!got1 || at1 !== acc1 + 8) begin
            bad++; $display("FAIL b2b_first_latency: got=%0b at %0d want %0d", got1, at1, acc1 + 8);
        end
        total++; if (m_if.LED !== pop_main()) begin bad++; $display("FAIL b2b_first_led: got %b want 11100", m_if.LED); end
        @(negedge clk);
        m_if.start = 1'b0;
        total++; if (m_if.ready !== 1'b0) begin bad++; $display("FAIL b2b_accept: ready %b want 0", m_if.ready); end
        hold_ok = 1'b1;
        got2    = 1'b0;
        at2     = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_if.done) begin
                got2 = 1'b1;
                at2  = cyc;
                break;
            end
            if (m_if.LED !== 5'b11100) hold_ok = 1'b0;
            @(negedge clk);
        end
        total++; if (!hold_ok) begin bad++; $display("FAIL b2b_led_hold: led changed during scan, want 11100"); end
        total++; if (!got2 || at2 - at1 !== 9) begin
            bad++; $display("FAIL b2b_spacing: got=%0b spacing %0d want 9", got2, at2 - at1);
        end
        total++; if (m_if.LED !== pop_main()) begin bad++; $display("FAIL b2b_second_led: got %b want 00010", m_if.LED); end
    endtask

    task automatic test_ignore_busy_start();
        int acc, at;
        bit got, ready_low, extra;
        start_main(8'd30, 5'b11011, acc);
        repeat (2) @(negedge clk);
        m_if.num   = 8'd7;
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        ready_low = 1'b1;
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_if.done) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
            if (m_if.ready !== 1'b0) ready_low = 1'b0;
            @(negedge clk);
        end
        total++; if (!ready_low) begin bad++; $display("FAIL ignore_ready: ready rose before done, want 0"); end
        total++; if (!got || at !== acc + 8) begin
            bad++; $display("FAIL ignore_latency: got=%0b at %0d want %0d", got, at, acc + 8);
        end
        total++; if (m_if.LED !== pop_main()) begin bad++; $display("FAIL ignore_led: got %b want 11011", m_if.LED); end
        extra = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (m_if.done || !m_if.ready) extra = 1'b1;
        end
        total++; if (extra) begin bad++; $display("FAIL ignore_no_second_scan: extra activity seen, want idle"); end
    endtask

    task automatic test_reset_mid_scan();
        int acc, at;
        bit got, stray;
        start_main(8'd240, 5'b11111, acc);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        total++; if (m_if.LED !== 5'b00000 || m_if.ready !== 1'b1 || m_if.done !== 1'b0) begin
            bad++; $display("FAIL midreset_state: led %b ready %b done %b want 00000 1 0", m_if.LED, m_if.ready, m_if.done);
        end
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (m_if.done) stray = 1'b1;
        end
        total++; if (stray) begin bad++; $display("FAIL midreset_done: done pulsed for aborted scan, want none"); end
        start_main(8'd25, 5'b00010, acc);
        wait_done(0, 20, got, at);
        total++; if (!got || m_if.LED !== pop_main()) begin
            bad++; $display("FAIL midreset_recover: got=%0b led %b want 00010", got, m_if.LED);
        end
    endtask

    task automatic test_override();
        int acc, at;
        bit got;
        logic [4:0] e;
        logic [7:0] nums [5] = '{8'd0, 8'd7, 8'd45, 8'd1, 8'd255};
        @(negedge clk);
        big_if.num   = 12'd3003;
        big_if.start = 1'b1;
        big_q.push_back(5'b10111);
        acc = cyc + 1;
        @(negedge clk);
        big_if.start = 1'b0;
        wait_done(1, 30, got, at);
        e = big_q.pop_front();
        total++; if (!got || at !== acc + 12) begin
            bad++; $display("FAIL big_latency: got=%0b at %0d want %0d", got, at, acc + 12);
        end
        total++; if (big_if.LED !== e) begin bad++; $display("FAIL big_led: got %b want %b", big_if.LED, e); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            edge_if.num   = nums[k];
            edge_if.start = 1'b1;
            edge_q.push_back(model_led(int'(nums[k]), EDGE_DIVS));
            @(negedge clk);
            edge_if.start = 1'b0;
            wait_done(2, 20, got, at);
            e = edge_q.pop_front();
            total++; if (!got || edge_if.LED !== e) begin
                bad++; $display("FAIL edge_led num=%0d: got=%0b led %b want %b", nums[k], got, edge_if.LED, e);
            end
            total++; if (edge_if.LED[4] !== 1'b1 || edge_if.LED[3] !== 1'b0) begin
                bad++; $display("FAIL edge_fields num=%0d: bit4 %b bit3 %b want 1 0", nums[k], edge_if.LED[4], edge_if.LED[3]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_back_to_back();
        test_ignore_busy_start();
        test_reset_mid_scan();
        test_override();
        total++; if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: %0d expected results left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
